// File: rtl/secure_key_sib_if.sv
// Scan-path bundle between an IJTAG parent network and a secure_key_sib.
// The master side drives scan data and enables; the slave side is the SIB.
interface secure_key_sib_if #(
  parameter int MAX_FAIL = 3
);
  localparam int CNT_W = $clog2(MAX_FAIL + 1);

  logic             SI;
  logic             FromSO;
  logic             ShiftEN;
  logic             CaptureEN;
  logic             UpdateEN;
  logic             Select;
  logic             SO;
  logic             ToSI;
  logic             ToSelect;
  logic             Locked;
  logic [CNT_W-1:0] FailCnt;

  modport master (
    output SI, FromSO, ShiftEN, CaptureEN,
    output UpdateEN, Select,
    input  SO, ToSI, ToSelect, Locked, FailCnt
  );

  modport slave (
    input  SI, FromSO, ShiftEN, CaptureEN,
    input  UpdateEN, Select,
    output SO, ToSI, ToSelect, Locked, FailCnt
  );
endinterface

// File: rtl/secure_key_sib.sv
// Key-protected SIB: an in-chain key register must match KEY on update
// to open the sub-segment; MAX_FAIL mismatches lock it until reset.
module secure_key_sib #(
  parameter int              KEY_W    = 8,
  parameter logic [KEY_W-1:0] KEY     = KEY_W'('hA5),
  parameter int              MAX_FAIL = 3,
  parameter int              CNT_W    = $clog2(MAX_FAIL + 1)
) (
  input logic           Clock,
  input logic           RstBar,
  secure_key_sib_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FAIL);

  logic [KEY_W-1:0] r_key_sr;
  logic             r_sib;
  logic             r_open;
  logic             r_locked;
  logic [CNT_W-1:0] r_fail;

  logic [KEY_W-1:0] w_key_nxt;
  logic [KEY_W-1:0] w_key_shift;
  logic             w_sib_nxt;
  logic             w_open_nxt;
  logic             w_locked_nxt;
  logic [CNT_W-1:0] w_fail_nxt;
  logic [CNT_W-1:0] w_fail_inc;
  logic             w_cap;
  logic             w_shift;
  logic             w_upd;
  logic             w_match;

  // Capture beats shift beats update; only one ever acts.
  assign w_cap   = bus.Select & bus.CaptureEN;
  assign w_shift = bus.Select & bus.ShiftEN
                 & ~bus.CaptureEN;
  assign w_upd   = bus.Select & bus.UpdateEN
                 & ~bus.CaptureEN & ~bus.ShiftEN;

  assign w_match    = (r_key_sr == KEY);
  assign w_fail_inc = r_fail + CNT_W'(1);

  generate
    if (KEY_W == 1) begin : g_key1
      assign w_key_shift = bus.SI;
    end else begin : g_keyn
      assign w_key_shift = {bus.SI, r_key_sr[KEY_W-1:1]};
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!RstBar) begin
      r_key_sr <= '0;
      r_sib    <= 1'b0;
      r_open   <= 1'b0;
      r_locked <= 1'b0;
      r_fail   <= '0;
    end else begin
      r_key_sr <= w_key_nxt;
      r_sib    <= w_sib_nxt;
      r_open   <= w_open_nxt;
      r_locked <= w_locked_nxt;
      r_fail   <= w_fail_nxt;
    end
  end

  always_comb begin
    w_key_nxt    = r_key_sr;
    w_sib_nxt    = r_sib;
    w_open_nxt   = r_open;
    w_locked_nxt = r_locked;
    w_fail_nxt   = r_fail;
    unique case (1'b1)
      w_cap: begin
        // Only the lock flag is observable; the key never leaks.
        w_sib_nxt = r_open;
        w_key_nxt = KEY_W'(r_locked);
      end
      w_shift: begin
        w_key_nxt = w_key_shift;
        w_sib_nxt = r_open ? bus.FromSO : r_key_sr[0];
      end
      w_upd: begin
        w_key_nxt = '0;
        if (r_locked) begin
          w_open_nxt = 1'b0;
        end else if (w_match) begin
          w_open_nxt = r_sib;
          w_fail_nxt = '0;
        end else begin
          w_open_nxt = 1'b0;
          if (r_fail != CNT_MAX)
            w_fail_nxt = w_fail_inc;
          if (w_fail_inc == CNT_MAX)
            w_locked_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.SO       = r_sib;
  assign bus.ToSI     = r_key_sr[0];
  assign bus.ToSelect = r_open & bus.Select;
  assign bus.Locked   = r_locked;
  assign bus.FailCnt  = r_fail;

endmodule

// File: doc/secure_key_sib.md
# secure_key_sib

Parametrised key-protected Segment Insertion Bit (SIB) for IJTAG networks. It generalises the single-bit secure SIB: it carries an internal KEY_W-bit key shift register in the scan path and compares it against a hard-wired key on every update, instead of taking an external comparator result. It counts failed unlock attempts and permanently locks the sub-segment closed after MAX_FAIL failures, until reset. It sits in the scan network between a parent SI/SO path and one gated sub-segment.

## Interface
- KEY_W, 8, key register width (>=1)
- KEY, 'hA5, KEY_W-bit unlock key
- MAX_FAIL, 3, failed updates before permanent lock (>=1)
- CNT_W, $clog2(MAX_FAIL+1), failure counter width (derived; do not override)

- Clock  in  1  scan clock; all state on rising edge
- RstBar  in  1  synchronous active-low reset
- SI  in  1  scan input from parent path
- FromSO  in  1  scan output returning from sub-segment
- ShiftEN, CaptureEN, UpdateEN  in  1 each  IJTAG operation enables
- Select  in  1  this SIB is on the active path
- SO  out  1  scan output (= sib_sr)
- ToSI  out  1  scan input to sub-segment (= key_sr[0])
- ToSelect  out  1  open & Select
- Locked  out  1  lock flag
- FailCnt  out  CNT_W  current failure count

## Operation
- State: key_sr[KEY_W-1:0], sib_sr, open, locked, fail_cnt.
- Chain order, closed: SI -> key_sr[KEY_W-1] ... key_sr[0] -> sib_sr -> SO (length KEY_W+1).
- Chain order, open: SI -> key_sr -> ToSI -> sub-segment -> FromSO -> sib_sr -> SO.
- Gating: only act when Select=1. With Select=0, all state holds.
- Priority when several enables are high: Capture > Shift > Update. Only the highest one acts.
- Shift:
  - key_sr <= {SI, key_sr[KEY_W-1:1]}.
  - sib_sr <= open ? FromSO : key_sr[0].
- Capture:
  - sib_sr <= open.
  - key_sr <= {KEY_W-1 zeros, locked}. The key is never exposed on capture.
- Update, locked=0, key_sr==KEY:
  - open <= sib_sr.
  - fail_cnt <= 0.
- Update, locked=0, key_sr!=KEY:
  - open <= 0.
  - fail_cnt <= fail_cnt+1, saturating at MAX_FAIL.
  - locked <= 1 when fail_cnt+1 == MAX_FAIL.
- Update, locked=1:
  - open stays 0 and fail_cnt holds.
- Every update, locked or not: key_sr <= 0 (zeroise) and sib_sr holds.
- Locked forces open=0. Only RstBar low clears locked.

## Timing
- Reset (RstBar low at an edge): key_sr=0, sib_sr=0, open=0, locked=0, fail_cnt=0.
  - Resulting outputs: SO=0, ToSI=0, ToSelect=0, Locked=0, FailCnt=0.
  - Reset overrides all enables, including mid-shift or mid-update.
- Update latency: open, locked and fail_cnt change on the same edge as the UpdateEN cycle. ToSelect and Locked reflect the change the following cycle.
- Shift: 1 bit per cycle. SO is registered (sib_sr), so there is no combinational SI->SO path. ToSI is registered.
- ToSelect is combinational in Select: it drops the same cycle Select drops.
- fail_cnt never exceeds MAX_FAIL. A correct key before the lock threshold resets it to 0.
- A correct key on the same update that would have been the MAX_FAIL-th failure is not a failure. Matching is decided on key_sr before zeroisation.

## Test plan
(KEY_W=8, KEY=8'hA5, MAX_FAIL=3)
- Reset, then shift 9 bits (sib=1, key=A5, key LSB first), then update -> ToSelect=1 next cycle, FailCnt=0, key_sr=0.
- While open, shift 12 cycles with FromSO driven by a 3-bit external segment -> SO stream equals the FromSO stream delayed 1 cycle; ToSI equals SI delayed 8.
- Shift sib=1 with key=5A, then update, three times -> FailCnt goes 1,2,3; Locked=1 after the third; ToSelect=0.
- While locked, shift sib=1 with key=A5, then update -> ToSelect stays 0, FailCnt=3; capture then shift out 9 bits -> captured key_sr reads 8'h01 and SO first bit = 0.
- Two bad updates, then a good one with sib=0 -> FailCnt=0, open=0, Locked=0.
- Assert CaptureEN, ShiftEN and UpdateEN together -> capture only. Pulse RstBar low during shift -> all outputs 0 next cycle.
